// File: rtl/integrator_pkg.sv
// Shared constants, register map and FSM state encoding for the Euler integrator slave.
package integrator_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned FRAC   = 16;
  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam int unsigned LEN_W  = ADDR_W + 1;

  localparam logic [ADDR_W-1:0] REG_CTRL     = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] REG_STATUS   = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] REG_LENGTH   = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] REG_SCALE    = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] REG_CYCLES   = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] REG_ACC_INIT = ADDR_W'(5);

  localparam int unsigned CTRL_START   = 0;
  localparam int unsigned CTRL_CLR_ERR = 1;

  localparam int unsigned STAT_BUSY = 0;
  localparam int unsigned STAT_DONE = 1;
  localparam int unsigned STAT_ERR  = 2;
  localparam int unsigned STAT_OVF  = 3;

  localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, FETCH, MAC, STORE, DONE} state_e;

endpackage

// File: rtl/integrator_engine_slave_if.sv
// Avalon-MM bundle for the data_in / data_control / data_out ports of the integrator slave.
interface integrator_engine_slave_if;
  import integrator_pkg::*;

  logic              data_in_write;
  logic [DATA_W-1:0] data_in_writedata;
  logic [ADDR_W-1:0] data_in_address;
  logic [DATA_W-1:0] data_control_writedata;
  logic [DATA_W-1:0] data_control_readdata;
  logic [ADDR_W-1:0] data_control_address;
  logic              data_control_read;
  logic              data_control_write;
  logic [DATA_W-1:0] data_out_readdata;
  logic [ADDR_W-1:0] data_out_address;

  modport master (
    output data_in_write, data_in_writedata, data_in_address,
    output data_control_writedata, data_control_address, data_control_read, data_control_write,
    output data_out_address,
    input  data_control_readdata, data_out_readdata
  );

  modport slave (
    input  data_in_write, data_in_writedata, data_in_address,
    input  data_control_writedata, data_control_address, data_control_read, data_control_write,
    input  data_out_address,
    output data_control_readdata, data_out_readdata
  );
endinterface

// File: rtl/dp_ram.sv
// Simple dual-port RAM: one write port, one read port with registered (latency 1) output.
module dp_ram #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [0:(1<<AW)-1];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) rdata_o <= '0;
    else       rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/integrator_engine_slave.sv
// Forward-Euler integrator: acc += (in[i]*SCALE) >>> FRAC, one element per three cycles.
// Optional build macro SATURATE_EN: saturating MAC/accumulate with sticky OVF status.
module integrator_engine_slave
  import integrator_pkg::*;
(
  input  logic                      clk_clk,
  input  logic                      reset_reset,
  integrator_engine_slave_if.slave  bus
);

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  length_q, n_q, n_d;
  logic [ADDR_W-1:0] i_q, i_d;
  logic [DATA_W-1:0] scale_q, scale_run_q, scale_run_d, acc_init_q;
  logic [DATA_W-1:0] acc_q, acc_d, term_q, term_d, cycles_q, cycles_d;
  logic              done_q, done_d, err_q;
  logic [DATA_W-1:0] ctrl_rdata_q, ctrl_rdata_c, ibuf_rdata, obuf_rdata;
  logic              busy_c, ctrl_wr_c, start_c, clr_err_c, obuf_we_c, ovf_c;
  logic signed [2*DATA_W-1:0] product_c, shifted_c;
  logic [DATA_W:0]   sum_c;
  logic [DATA_W-1:0] mac_term_c, add_c;

  assign busy_c    = (state_q != IDLE);
  assign ctrl_wr_c = bus.data_control_write;
  assign start_c   = ctrl_wr_c && (bus.data_control_address == REG_CTRL)
                     && bus.data_control_writedata[CTRL_START];
  assign clr_err_c = ctrl_wr_c && (bus.data_control_address == REG_CTRL)
                     && bus.data_control_writedata[CTRL_CLR_ERR];

  dp_ram #(.DW(DATA_W), .AW(ADDR_W)) u_ibuf (
    .clk_i   (clk_clk),
    .rst_i   (reset_reset),
    .we_i    (bus.data_in_write && !busy_c),
    .waddr_i (bus.data_in_address),
    .wdata_i (bus.data_in_writedata),
    .raddr_i (i_q),
    .rdata_o (ibuf_rdata)
  );

  dp_ram #(.DW(DATA_W), .AW(ADDR_W)) u_obuf (
    .clk_i   (clk_clk),
    .rst_i   (reset_reset),
    .we_i    (obuf_we_c),
    .waddr_i (i_q),
    .wdata_i (add_c),
    .raddr_i (bus.data_out_address),
    .rdata_o (obuf_rdata)
  );

  assign bus.data_out_readdata     = obuf_rdata;
  assign bus.data_control_readdata = ctrl_rdata_q;

  // MAC term and accumulate, wrapping by default
  always_comb begin
    product_c  = $signed({{DATA_W{ibuf_rdata[DATA_W-1]}}, ibuf_rdata})
               * $signed({{DATA_W{scale_run_q[DATA_W-1]}}, scale_run_q});
    shifted_c  = product_c >>> FRAC;
    sum_c      = {acc_q[DATA_W-1], acc_q} + {term_q[DATA_W-1], term_q};
    mac_term_c = DATA_W'(shifted_c);
    add_c      = DATA_W'(sum_c);
`ifdef SATURATE_EN
    if (shifted_c[2*DATA_W-1:DATA_W-1] != {(DATA_W+1){shifted_c[2*DATA_W-1]}})
      mac_term_c = shifted_c[2*DATA_W-1] ? SAT_MIN : SAT_MAX;
    if (sum_c[DATA_W] != sum_c[DATA_W-1])
      add_c = sum_c[DATA_W] ? SAT_MIN : SAT_MAX;
`endif
  end

`ifdef SATURATE_EN
  logic ovf_q, ovf_set_c;
  assign ovf_set_c =
      ((state_q == MAC)   && (mac_term_c != DATA_W'(shifted_c))) ||
      ((state_q == STORE) && (add_c != DATA_W'(sum_c)));

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset)                        ovf_q <= 1'b0;
    else if (ovf_set_c)                     ovf_q <= 1'b1;
    else if ((start_c && !busy_c) || clr_err_c) ovf_q <= 1'b0;
  end
  assign ovf_c = ovf_q;
`else
  assign ovf_c = 1'b0;
`endif

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state_q     <= IDLE;
      n_q         <= '0;
      i_q         <= '0;
      scale_run_q <= '0;
      acc_q       <= '0;
      term_q      <= '0;
      cycles_q    <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      i_q         <= i_d;
      scale_run_q <= scale_run_d;
      acc_q       <= acc_d;
      term_q      <= term_d;
      cycles_q    <= cycles_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    i_d         = i_q;
    scale_run_d = scale_run_q;
    acc_d       = acc_q;
    term_d      = term_q;
    cycles_d    = busy_c ? cycles_q + 1'b1 : cycles_q;
    done_d      = done_q;
    obuf_we_c   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_c) begin
          n_d         = (length_q > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : length_q;
          acc_d       = acc_init_q;
          scale_run_d = scale_q;
          i_d         = '0;
          done_d      = 1'b0;
          // the START cycle itself is counted
          cycles_d    = DATA_W'(1);
          state_d     = (n_d == '0) ? DONE : FETCH;
        end
      end
      FETCH: state_d = MAC;
      MAC: begin
        term_d  = mac_term_c;
        state_d = STORE;
      end
      STORE: begin
        acc_d     = add_c;
        obuf_we_c = 1'b1;
        if (LEN_W'(i_q) == n_q - 1'b1) begin
          state_d = DONE;
        end else begin
          i_d     = i_q + 1'b1;
          state_d = FETCH;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Host-visible registers and sticky error
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      length_q     <= '0;
      scale_q      <= '0;
      acc_init_q   <= '0;
      err_q        <= 1'b0;
      ctrl_rdata_q <= '0;
    end else begin
      if (ctrl_wr_c && bus.data_control_address == REG_LENGTH)
        length_q <= bus.data_control_writedata[LEN_W-1:0];
      if (ctrl_wr_c && bus.data_control_address == REG_SCALE)
        scale_q <= bus.data_control_writedata;
      if (ctrl_wr_c && bus.data_control_address == REG_ACC_INIT)
        acc_init_q <= bus.data_control_writedata;
      if (bus.data_in_write && busy_c) err_q <= 1'b1;
      else if (clr_err_c)              err_q <= 1'b0;
      if (bus.data_control_read) ctrl_rdata_q <= ctrl_rdata_c;
    end
  end

  always_comb begin
    ctrl_rdata_c = '0;
    case (bus.data_control_address)
      REG_STATUS: begin
        ctrl_rdata_c[STAT_BUSY] = busy_c;
        ctrl_rdata_c[STAT_DONE] = done_q;
        ctrl_rdata_c[STAT_ERR]  = err_q;
        ctrl_rdata_c[STAT_OVF]  = ovf_c;
      end
      REG_LENGTH:   ctrl_rdata_c = DATA_W'(length_q);
      REG_SCALE:    ctrl_rdata_c = scale_q;
      REG_CYCLES:   ctrl_rdata_c = cycles_q;
      REG_ACC_INIT: ctrl_rdata_c = acc_init_q;
      default:      ctrl_rdata_c = '0;
    endcase
  end

endmodule

// File: tb/tb_integrator_engine_slave.sv
// Directed + randomized bench for integrator_engine_slave with an arithmetic reference model.
module tb_integrator_engine_slave;
  import integrator_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  integrator_engine_slave_if bus();
  integrator_engine_slave dut (.clk_clk(clk), .reset_reset(rst), .bus(bus));

  int errors = 0;
  int checks = 0;

  logic [31:0] ibuf_m [256];
  logic [31:0] obuf_m [256];
  logic [31:0] scale_m, acc_init_m;
  int          len_m;
  bit          ovf_m, err_m;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ctrl_write(input logic [7:0] a, input logic [31:0] d);
    bus.data_control_address   = a;
    bus.data_control_writedata = d;
    bus.data_control_write     = 1'b1;
    @(posedge clk); #1;
    bus.data_control_write     = 1'b0;
  endtask

  task automatic ctrl_read(input logic [7:0] a, output logic [31:0] d);
    bus.data_control_address = a;
    bus.data_control_read    = 1'b1;
    @(posedge clk); #1;
    bus.data_control_read    = 1'b0;
    d = bus.data_control_readdata;
  endtask

  task automatic in_write(input logic [7:0] a, input logic [31:0] d);
    bus.data_in_address   = a;
    bus.data_in_writedata = d;
    bus.data_in_write     = 1'b1;
    @(posedge clk); #1;
    bus.data_in_write     = 1'b0;
  endtask

  task automatic load(input int a, input logic [31:0] d);
    in_write(8'(a), d);
    ibuf_m[a] = d;
  endtask

  task automatic out_read(input int a, output logic [31:0] d);
    bus.data_out_address = 8'(a);
    @(posedge clk); #1;
    d = bus.data_out_readdata;
  endtask

  task automatic setup(input int len, input logic [31:0] sc, input logic [31:0] ai);
    ctrl_write(REG_LENGTH, 32'(len));
    ctrl_write(REG_SCALE, sc);
    ctrl_write(REG_ACC_INIT, ai);
    len_m = len; scale_m = sc; acc_init_m = ai;
  endtask

  // Reference: integrate the first min(len, DEPTH, limit) samples with plain 64-bit arithmetic
  task automatic model_run(input int limit);
    int n;
    longint acc, p, t;
    n = (len_m > 256) ? 256 : len_m;
    if (limit < n) n = limit;
    ovf_m = 1'b0;
    acc = longint'($signed(acc_init_m));
    for (int i = 0; i < n; i++) begin
      p = longint'($signed(ibuf_m[i])) * longint'($signed(scale_m));
      t = p >>> 16;
`ifdef SATURATE_EN
      if (t > 64'sd2147483647)       begin t = 64'sd2147483647;  ovf_m = 1'b1; end
      else if (t < -64'sd2147483648) begin t = -64'sd2147483648; ovf_m = 1'b1; end
      acc = acc + t;
      if (acc > 64'sd2147483647)       begin acc = 64'sd2147483647;  ovf_m = 1'b1; end
      else if (acc < -64'sd2147483648) begin acc = -64'sd2147483648; ovf_m = 1'b1; end
`else
      t = longint'($signed(t[31:0]));
      acc = acc + t;
      acc = longint'($signed(acc[31:0]));
`endif
      obuf_m[i] = acc[31:0];
    end
  endtask

  task automatic wait_done(output int polls);
    logic [31:0] st;
    polls = 0;
    do begin
      ctrl_read(REG_STATUS, st);
      polls++;
    end while (!st[1] && polls < 5000);
    check("run_done_seen", 32'(st[1]), 32'd1);
  endtask

  // Start a run, verify latency, CYCLES, STATUS and every output word
  task automatic run_and_check(input string tag);
    int polls, n;
    logic [31:0] d;
    n = (len_m > 256) ? 256 : len_m;
    ctrl_write(REG_CTRL, 32'h1);
    wait_done(polls);
    model_run(256);
    check({tag, "_done_latency"}, 32'(polls), 32'(3*n + 2));
    ctrl_read(REG_CYCLES, d);
    check({tag, "_cycles"}, d, 32'(3*n + 2));
    ctrl_read(REG_STATUS, d);
    check({tag, "_status"}, d, {28'd0, ovf_m, err_m, 1'b1, 1'b0});
    for (int i = 0; i < n; i++) begin
      out_read(i, d);
      check($sformatf("%s_obuf%0d", tag, i), d, obuf_m[i]);
    end
  endtask

  initial begin
    logic [31:0] d, keep;
    int polls;
    rst = 1'b1;
    bus.data_in_write = 1'b0; bus.data_in_writedata = '0; bus.data_in_address = '0;
    bus.data_control_write = 1'b0; bus.data_control_read = 1'b0;
    bus.data_control_writedata = '0; bus.data_control_address = '0;
    bus.data_out_address = '0;
    err_m = 1'b0; ovf_m = 1'b0;
    tick(3);
    check("reset_ctrl_rdata", bus.data_control_readdata, 32'd0);
    check("reset_out_rdata",  bus.data_out_readdata,     32'd0);
    rst = 1'b0;
    tick(1);
    ctrl_read(REG_STATUS, d);   check("reset_status", d, 32'd0);
    ctrl_read(REG_LENGTH, d);   check("reset_length", d, 32'd0);
    ctrl_read(REG_SCALE, d);    check("reset_scale",  d, 32'd0);
    ctrl_read(8'd9, d);         check("unmapped_read", d, 32'd0);

    // Unit gain, {1,2,3}
    load(0, 32'd1); load(1, 32'd2); load(2, 32'd3);
    setup(3, 32'h0001_0000, 32'd0);
    run_and_check("t1");
    out_read(2, d); check("t1_literal_sum", d, 32'd6);

    // Half gain with negative sample and nonzero initial value
    load(0, 32'd4); load(1, -32'sd6);
    setup(2, 32'h0000_8000, 32'd10);
    run_and_check("t2");
    out_read(1, d); check("t2_literal_last", d, 32'd9);

    // LENGTH = 0 completes at once and leaves obuf untouched
    out_read(0, keep);
    setup(0, 32'h0001_0000, 32'd77);
    ctrl_write(REG_CTRL, 32'h1);
    wait_done(polls);
    check("len0_latency", 32'(polls), 32'd2);
    out_read(0, d); check("len0_obuf_kept", d, keep);

    // Randomized runs
    for (int r = 0; r < 4; r++) begin
      int len;
      len = $urandom_range(1, 12);
      for (int i = 0; i < len; i++) load(i, $urandom);
      setup(len, $urandom, $urandom);
      run_and_check($sformatf("rnd%0d", r));
    end

    // LENGTH beyond DEPTH clamps to 256 elements
    for (int i = 0; i < 256; i++) load(i, $urandom_range(0, 2000) - 1000);
    setup(300, $urandom_range(0, 32'h0002_0000), $urandom_range(0, 5000));
    run_and_check("clamp");
    ctrl_read(REG_LENGTH, d); check("clamp_len_reg", d, 32'd300);

    // Sample write during a run is dropped and flags ERR
    setup(4, 32'h0001_0000, 32'd0);
    ctrl_write(REG_CTRL, 32'h1);
    in_write(8'd5, 32'hDEAD_BEEF);
    wait_done(polls);
    model_run(256);
    ctrl_read(REG_STATUS, d); check("err_set", d, {28'd0, ovf_m, 1'b1, 1'b1, 1'b0});
    ctrl_write(REG_CTRL, 32'h2);
    ctrl_read(REG_STATUS, d); check("err_cleared", d, 32'h2);
    setup(6, 32'h0001_0000, 32'd0);
    run_and_check("ibuf5_kept");

    // Second START and LENGTH rewrite mid-run do not disturb the current run
    setup(5, 32'h0001_8000, 32'd3);
    ctrl_write(REG_CTRL, 32'h1);
    tick(2);
    ctrl_write(REG_CTRL, 32'h1);
    ctrl_write(REG_LENGTH, 32'd2);
    wait_done(polls);
    model_run(256);
    ctrl_read(REG_CYCLES, d); check("midstart_cycles", d, 32'd17);
    ctrl_read(REG_LENGTH, d); check("midrun_len_reg", d, 32'd2);
    for (int i = 0; i < 5; i++) begin
      out_read(i, d); check($sformatf("midrun_obuf%0d", i), d, obuf_m[i]);
    end

    // Saturation corner
    load(0, 32'h20);
    setup(1, 32'h0001_0000, 32'h7FFF_FFF0);
    ctrl_write(REG_CTRL, 32'h1);
    wait_done(polls);
    model_run(256);
    out_read(0, d);
    check("sat_obuf_model", d, obuf_m[0]);
    ctrl_read(REG_STATUS, d);
`ifdef SATURATE_EN
    check("sat_obuf_literal", obuf_m[0], 32'h7FFF_FFFF);
    check("sat_ovf_set", d, 32'hA);
    ctrl_write(REG_CTRL, 32'h2);
    ctrl_read(REG_STATUS, d); check("sat_ovf_cleared", d, 32'h2);
`else
    check("wrap_obuf_literal", obuf_m[0], 32'h8000_0010);
    check("wrap_status_no_ovf", d, 32'h2);
`endif

    // Reset in the middle of a run
    load(0, 32'd7); load(1, 32'd9); load(2, 32'd11); load(3, 32'd13);
    setup(4, 32'h0001_0000, 32'd0);
    model_run(2);
    bus.data_out_address = 8'd0;
    ctrl_write(REG_CTRL, 32'h1);
    tick(7);
    ctrl_read(REG_LENGTH, d); check("pre_reset_len", d, 32'd4);
    rst = 1'b1;
    #1;
    check("midreset_ctrl_rdata", bus.data_control_readdata, 32'd0);
    check("midreset_out_rdata",  bus.data_out_readdata,     32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    ctrl_read(REG_STATUS, d); check("post_reset_status", d, 32'd0);
    ctrl_read(REG_LENGTH, d); check("post_reset_length", d, 32'd0);
    out_read(0, d); check("partial_obuf0", d, obuf_m[0]);
    out_read(1, d); check("partial_obuf1", d, obuf_m[1]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
